// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS subset (add/sub/and/or/slt, lw, sw, beq, addi, j).
// One shared memory port carries both instruction fetch and data access, using a req/ready handshake.
// Each instruction passes through 3-5 states, with extra cycles while memory holds ready low.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          ADDR_W          = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              halted,
  output logic [3:0]        state_dbg
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,  S_ADDIWB = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam state_t ILL_NEXT = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;

  state_t      state;
  logic [31:0] ir, a, b, alu_out, mdr;
  logic [31:0] rf [32];
  logic        wr_gap;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] pc_ext, imm_ext, jump_target;
  logic        accept;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h25) || (f == 6'h2A);
  endfunction

  function automatic logic [2:0] alu_ctl(input logic [5:0] f);
    case (f)
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [31:0] alu_op(input logic [2:0] ctl, input logic signed [31:0] x,
                                         input logic signed [31:0] y);
    case (ctl)
      3'b110:  return x - y;
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b111:  return (x < y) ? 32'd1 : 32'd0;
      default: return x + y;
    endcase
  endfunction

  assign op          = ir[31:26];
  assign rs          = ir[25:21];
  assign rt          = ir[20:16];
  assign rd          = ir[15:11];
  assign funct       = ir[5:0];
  assign imm         = ir[15:0];
  assign pc_ext      = 32'(pc);
  assign imm_ext     = sext16(imm);
  assign jump_target = {pc_ext[31:28], ir[25:0], 2'b00};

  // The request gap after a store keeps mem_req from staying high straight into the next fetch;
  // gating with reset makes the request fall the moment reset is asserted.
  assign mem_req   = reset && !wr_gap &&
                     ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR));
  assign mem_we    = (state == S_MEMWR);
  assign mem_addr  = (state == S_FETCH) ? pc : alu_out[ADDR_W-1:0];
  assign mem_wdata = b;
  assign accept    = mem_req && mem_ready;
  assign halted    = (state == S_HALT);
  assign state_dbg = state;

  // Register-file write port selection for the three write-back states.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = rt;
    rf_wd = alu_out;
    case (state)
      S_MEMWB:  begin rf_we = 1'b1; rf_wa = rt; rf_wd = mdr;     end
      S_ALUWB:  begin rf_we = 1'b1; rf_wa = rd; rf_wd = alu_out; end
      S_ADDIWB: begin rf_we = 1'b1; rf_wa = rt; rf_wd = alu_out; end
      default:  ;
    endcase
  end

  // Register file: not reset; r0 is never written and reads back as zero.
  always_ff @(posedge clk) begin
    if (rf_we && (rf_wa != 5'd0)) rf[rf_wa] <= rf_wd;
  end

  // Controller FSM and datapath registers; retire pulses on the edge that completes an instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      pc      <= RESET_PC[ADDR_W-1:0];
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      retire  <= 1'b0;
      wr_gap  <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          if (wr_gap) begin
            wr_gap <= 1'b0;
          end else if (accept) begin
            ir    <= mem_rdata;
            pc    <= pc + ADDR_W'(4);
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a       <= (rs == 5'd0) ? 32'd0 : rf[rs];
          b       <= (rt == 5'd0) ? 32'd0 : rf[rt];
          alu_out <= pc_ext + (imm_ext << 2);
          case (op)
            OP_RTYPE: state <= funct_ok(funct) ? S_EXEC : ILL_NEXT;
            OP_LW,
            OP_SW:    state <= S_MEMADR;
            OP_ADDI:  state <= S_ADDIEX;
            OP_BEQ:   state <= S_BRANCH;
            OP_J:     state <= S_JUMP;
            default:  state <= ILL_NEXT;
          endcase
        end
        S_MEMADR: begin
          alu_out <= a + imm_ext;
          state   <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          if (accept) begin
            mdr   <= mem_rdata;
            state <= S_MEMWB;
          end
        end
        S_MEMWR: begin
          if (accept) begin
            retire <= 1'b1;
            wr_gap <= 1'b1;
            state  <= S_FETCH;
          end
        end
        S_EXEC: begin
          alu_out <= alu_op(alu_ctl(funct), a, b);
          state   <= S_ALUWB;
        end
        S_ADDIEX: begin
          alu_out <= a + imm_ext;
          state   <= S_ADDIWB;
        end
        S_BRANCH: begin
          if (a == b) pc <= alu_out[ADDR_W-1:0];
          retire <= 1'b1;
          state  <= S_FETCH;
        end
        S_JUMP: begin
          pc     <= jump_target[ADDR_W-1:0];
          retire <= 1'b1;
          state  <= S_FETCH;
        end
        S_MEMWB, S_ALUWB, S_ADDIWB: begin
          retire <= 1'b1;
          state  <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: a main core (reset PC 0, 32-bit addresses, halt on illegal)
// with a variable-latency memory, plus a second core (reset PC 0x20, 12-bit addresses,
// illegal executes as NOP) on an always-ready program ROM.
module tb_mips_multicycle_core;

  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [3:0]  state_dbg;

  logic        mem2_req, mem2_we, mem2_ready, retire2, halted2;
  logic [11:0] mem2_addr, pc2;
  logic [31:0] mem2_wdata, mem2_rdata;
  logic [3:0]  state2_dbg;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          rdy_delay = 0;
  int          wait_cnt = 0;
  bit          clr = 1'b0;
  logic [31:0] prog  [256];
  logic [31:0] prog2 [256];
  logic [31:0] dmem  [256];
  bit          dvalid [256];
  logic [31:0] obs_addr [64];
  logic [31:0] obs_data [64];
  int          obs_n = 0;
  int          hold_viol = 0;
  int          b2b_viol = 0;
  bit          prev_wait = 1'b0;
  bit          acc_prev = 1'b0;
  logic [31:0] p_addr, p_wdata;
  logic        p_we;

  logic [63:0] exp_wr [$];
  logic [31:0] exp_pc [$];
  logic [11:0] exp_pc2 [$];

  always #5 clk = ~clk;

  mips_multicycle_core dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .retire(retire), .halted(halted), .state_dbg(state_dbg)
  );

  mips_multicycle_core #(.RESET_PC(32'h0000_0020), .ADDR_W(12), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .reset(reset), .mem_req(mem2_req), .mem_we(mem2_we), .mem_addr(mem2_addr),
    .mem_wdata(mem2_wdata), .mem_rdata(mem2_rdata), .mem_ready(mem2_ready), .pc(pc2),
    .retire(retire2), .halted(halted2), .state_dbg(state2_dbg)
  );

  assign mem_ready  = mem_req && (wait_cnt >= rdy_delay);
  assign mem_rdata  = dvalid[mem_addr[9:2]] ? dmem[mem_addr[9:2]] : prog[mem_addr[9:2]];
  assign mem2_ready = 1'b1;
  assign mem2_rdata = prog2[mem2_addr[9:2]];

  // Memory model for the main core: wait-state counter, store log, handshake stability monitors.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) dvalid[i] <= 1'b0;
      obs_n     <= 0;
      hold_viol <= 0;
      b2b_viol  <= 0;
      wait_cnt  <= 0;
      prev_wait <= 1'b0;
      acc_prev  <= 1'b0;
    end else begin
      wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1 : 0;
      if (prev_wait && mem_req && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
        hold_viol <= hold_viol + 1;
      if (acc_prev && mem_req) b2b_viol <= b2b_viol + 1;
      prev_wait <= mem_req && !mem_ready;
      acc_prev  <= mem_req && mem_ready;
      p_addr    <= mem_addr;
      p_we      <= mem_we;
      p_wdata   <= mem_wdata;
      if (mem_req && mem_we && mem_ready) begin
        dmem[mem_addr[9:2]]   <= mem_wdata;
        dvalid[mem_addr[9:2]] <= 1'b1;
        if (obs_n < 64) begin
          obs_addr[obs_n] <= mem_addr;
          obs_data[obs_n] <= mem_wdata;
        end
        obs_n <= obs_n + 1;
      end
    end
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic begin_test();
    @(negedge clk);
    reset = 1'b0;
    rdy_delay = 0;
    for (int i = 0; i < 256; i++) prog[i] = HALT_W;
  endtask

  task automatic go();
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_to_halt(input int budget, output int cyc, output int rets);
    cyc = 0;
    rets = 0;
    while (!halted && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (retire) rets++;
    end
  endtask

  task automatic test_reset();
    begin_test();
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (retire !== 1'b0) begin n_fail++; $display("FAIL reset_retire: got %b want 0", retire); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 00000000", pc); end
    n_cmp++; if (state_dbg !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    n_cmp++; if (pc2 !== 12'h020) begin n_fail++; $display("FAIL reset_pc_param: got %h want 020", pc2); end
  endtask

  task automatic test_addi();
    int cyc, c2, r2;
    begin_test();
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0080);
    exp_wr.push_back({32'h80, 32'd5});
    go();
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!retire && cyc < 20);
    n_cmp++; if (cyc != 4) begin n_fail++; $display("FAIL addi_latency: got %0d cycles want 4", cyc); end
    n_cmp++; if (pc !== 32'h4) begin n_fail++; $display("FAIL addi_pc: got %h want 00000004", pc); end
    run_to_halt(100, c2, r2);
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL addi_halt_timeout: halted=%b want 1", halted); end
    n_cmp++; if (r2 != 1) begin n_fail++; $display("FAIL addi_retires: got %0d want 1", r2); end
    n_cmp++; if (obs_n != exp_wr.size()) begin n_fail++; $display("FAIL addi_wr_count: got %0d want %0d", obs_n, exp_wr.size()); end
    for (int k = 0; k < obs_n && exp_wr.size() > 0; k++) begin
      logic [63:0] e;
      e = exp_wr.pop_front();
      n_cmp++;
      if ({obs_addr[k], obs_data[k]} !== e) begin
        n_fail++; $display("FAIL addi_wr%0d: got %h/%h want %h/%h", k, obs_addr[k], obs_data[k], e[63:32], e[31:0]);
      end
    end
    exp_wr.delete();
  endtask

  task automatic test_alu();
    int cyc, rets;
    begin_test();
    prog[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    prog[2]  = enc_r(5'd2, 5'd0, 5'd3, 6'h2A);
    prog[3]  = enc_r(5'd0, 5'd2, 5'd4, 6'h22);
    prog[4]  = enc_r(5'd2, 5'd1, 5'd6, 6'h24);
    prog[5]  = enc_r(5'd2, 5'd1, 5'd7, 6'h25);
    prog[6]  = enc_r(5'd2, 5'd1, 5'd8, 6'h20);
    prog[7]  = enc_r(5'd1, 5'd2, 5'd9, 6'h2A);
    prog[8]  = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
    prog[9]  = enc_i(6'h04, 5'd1, 5'd0, 16'd1);
    prog[10] = enc_i(6'h2B, 5'd0, 5'd1, 16'h00A4);
    prog[11] = enc_i(6'h04, 5'd0, 5'd0, 16'd1);
    prog[12] = enc_i(6'h2B, 5'd0, 5'd1, 16'h00A8);
    prog[13] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0084);
    prog[14] = enc_i(6'h2B, 5'd0, 5'd4, 16'h0088);
    prog[15] = enc_i(6'h2B, 5'd0, 5'd6, 16'h008C);
    prog[16] = enc_i(6'h2B, 5'd0, 5'd7, 16'h0090);
    prog[17] = enc_i(6'h2B, 5'd0, 5'd8, 16'h0094);
    prog[18] = enc_i(6'h2B, 5'd0, 5'd9, 16'h0098);
    prog[19] = enc_i(6'h2B, 5'd0, 5'd0, 16'h009C);
    exp_wr.push_back({32'hA4, 32'd5});
    exp_wr.push_back({32'h84, 32'd1});
    exp_wr.push_back({32'h88, 32'd3});
    exp_wr.push_back({32'h8C, 32'd5});
    exp_wr.push_back({32'h90, 32'hFFFF_FFFD});
    exp_wr.push_back({32'h94, 32'd2});
    exp_wr.push_back({32'h98, 32'd0});
    exp_wr.push_back({32'h9C, 32'd0});
    go();
    run_to_halt(400, cyc, rets);
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL alu_halt_timeout: halted=%b want 1", halted); end
    n_cmp++; if (rets != 19) begin n_fail++; $display("FAIL alu_retires: got %0d want 19", rets); end
    n_cmp++; if (obs_n != exp_wr.size()) begin n_fail++; $display("FAIL alu_wr_count: got %0d want %0d", obs_n, exp_wr.size()); end
    for (int k = 0; k < obs_n && exp_wr.size() > 0; k++) begin
      logic [63:0] e;
      e = exp_wr.pop_front();
      n_cmp++;
      if ({obs_addr[k], obs_data[k]} !== e) begin
        n_fail++; $display("FAIL alu_wr%0d: got %h/%h want %h/%h", k, obs_addr[k], obs_data[k], e[63:32], e[31:0]);
      end
    end
    exp_wr.delete();
  endtask

  task automatic test_mem_wait();
    int cyc, rets, t0, t1;
    begin_test();
    rdy_delay = 3;
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0060);
    prog[2] = enc_i(6'h23, 5'd0, 5'd5, 16'h0060);
    prog[3] = enc_i(6'h2B, 5'd0, 5'd5, 16'h00A0);
    exp_wr.push_back({32'h60, 32'd5});
    exp_wr.push_back({32'hA0, 32'd5});
    go();
    cyc = 0; rets = 0; t0 = -1; t1 = -1;
    while (!halted && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (t0 < 0 && mem_req && !mem_we && mem_addr == 32'h8) t0 = cyc;
      if (retire) begin
        rets++;
        if (t0 >= 0 && t1 < 0) t1 = cyc;
      end
    end
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL wait_halt_timeout: halted=%b want 1", halted); end
    n_cmp++; if (rets != 4) begin n_fail++; $display("FAIL wait_retires: got %0d want 4", rets); end
    n_cmp++; if (t1 - t0 != 11) begin n_fail++; $display("FAIL wait_lw_latency: got %0d want 11", t1 - t0); end
    n_cmp++; if (hold_viol != 0) begin n_fail++; $display("FAIL wait_hold_stable: got %0d changes want 0", hold_viol); end
    n_cmp++; if (b2b_viol != 0) begin n_fail++; $display("FAIL wait_req_drop: got %0d want 0", b2b_viol); end
    n_cmp++; if (obs_n != exp_wr.size()) begin n_fail++; $display("FAIL wait_wr_count: got %0d want %0d", obs_n, exp_wr.size()); end
    for (int k = 0; k < obs_n && exp_wr.size() > 0; k++) begin
      logic [63:0] e;
      e = exp_wr.pop_front();
      n_cmp++;
      if ({obs_addr[k], obs_data[k]} !== e) begin
        n_fail++; $display("FAIL wait_wr%0d: got %h/%h want %h/%h", k, obs_addr[k], obs_data[k], e[63:32], e[31:0]);
      end
    end
    exp_wr.delete();
  endtask

  task automatic test_branch_jump();
    int cyc;
    logic [31:0] e;
    begin_test();
    prog[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1]  = {6'h02, 26'h000_0040};
    prog[64] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
    exp_pc.push_back(32'h4);
    exp_pc.push_back(32'h100);
    exp_pc.push_back(32'h100);
    exp_pc.push_back(32'h100);
    exp_pc.push_back(32'h100);
    go();
    cyc = 0;
    while (exp_pc.size() > 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (retire) begin
        e = exp_pc.pop_front();
        n_cmp++; if (pc !== e) begin n_fail++; $display("FAIL br_retire_pc: got %h want %h", pc, e); end
      end
    end
    n_cmp++; if (exp_pc.size() != 0) begin n_fail++; $display("FAIL br_timeout: %0d retires missing want 0", exp_pc.size()); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL br_halted: got %b want 0", halted); end
    exp_pc.delete();
  endtask

  task automatic test_illegal();
    int rets, req_h, saw24, cyc;
    logic [11:0] e2;
    begin_test();
    prog[0] = HALT_W;
    exp_pc2.push_back(12'h100);
    exp_pc2.push_back(12'h100);
    exp_pc2.push_back(12'h100);
    go();
    rets = 0; req_h = 0; saw24 = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (retire) rets++;
      if (halted && mem_req) req_h++;
      if (mem2_req && mem2_addr == 12'h024) saw24 = 1;
      if (retire2 && exp_pc2.size() > 0) begin
        e2 = exp_pc2.pop_front();
        n_cmp++; if (pc2 !== e2) begin n_fail++; $display("FAIL nop_retire_pc: got %h want %h", pc2, e2); end
      end
    end
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL ill_halted: got %b want 1", halted); end
    n_cmp++; if (rets != 0) begin n_fail++; $display("FAIL ill_retires: got %0d want 0", rets); end
    n_cmp++; if (req_h != 0) begin n_fail++; $display("FAIL ill_req_in_halt: got %0d want 0", req_h); end
    n_cmp++; if (pc !== 32'h4) begin n_fail++; $display("FAIL ill_pc: got %h want 00000004", pc); end
    n_cmp++; if (saw24 != 1) begin n_fail++; $display("FAIL nop_pc_advance: got %0d want 1", saw24); end
    n_cmp++; if (halted2 !== 1'b0) begin n_fail++; $display("FAIL nop_halted: got %b want 0", halted2); end
    n_cmp++; if (exp_pc2.size() != 0) begin n_fail++; $display("FAIL nop_timeout: %0d retires missing want 0", exp_pc2.size()); end
    exp_pc2.delete();
    begin_test();
    prog[0] = enc_r(5'd0, 5'd0, 5'd1, 6'h3F);
    go();
    run_to_halt(20, cyc, rets);
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL ill_funct_halted: got %b want 1", halted); end
    n_cmp++; if (rets != 0) begin n_fail++; $display("FAIL ill_funct_retires: got %0d want 0", rets); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    begin_test();
    rdy_delay = 6;
    prog[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1]  = enc_i(6'h2B, 5'd0, 5'd1, 16'h0070);
    prog[28] = 32'hDEAD_BEEF;
    go();
    cyc = 0;
    while (!(mem_req && mem_we) && cyc < 60) begin @(negedge clk); cyc++; end
    n_cmp++; if (!(mem_req && mem_we)) begin n_fail++; $display("FAIL rm_reach_memwr: req=%b we=%b want 1/1", mem_req, mem_we); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rm_req_async: got %b want 0", mem_req); end
    n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rm_pc_async: got %h want 00000000", pc); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (obs_n != 0 || dvalid[28] != 1'b0) begin n_fail++; $display("FAIL rm_mem_unchanged: writes=%0d want 0", obs_n); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (!(mem_req === 1'b1 && mem_addr === 32'h0 && mem_we === 1'b0)) begin
      n_fail++; $display("FAIL rm_refetch: req=%b addr=%h want 1/00000000", mem_req, mem_addr);
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 256; i++) prog2[i] = HALT_W;
    prog2[8]  = HALT_W;
    prog2[9]  = {6'h02, 26'h000_1040};
    prog2[64] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    test_reset();
    test_addi();
    test_alu();
    test_mem_wait();
    test_branch_jump();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
